// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encoding and defaults for the serializer
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bitcnt.sv
// rtl/bitcnt.sv - loadable down-counter with zero flag
module bitcnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    // load has priority; decrement saturates at zero so the count never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/serializer_8.sv
// rtl/serializer_8.sv - parallel-to-serial frame shifter with valid/ready handshake
module serializer_8
    import ser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             sout_nxt, valid_nxt, done_nxt, ready_nxt;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]    cnt;
    logic             accept;

    // bit that leaves the word first, depending on the configured order
    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // word with its outgoing bit removed, so head() yields the next bit
    function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    bitcnt #(.CW(CW)) u_bitcnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CW'(WIDTH - 1)),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // din_ready is a register, so accept depends only on din_valid and state
    assign accept = din_valid && din_ready;

    // next-state: load a new word, keep shifting, or fall back to idle
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        sout_nxt  = 1'b0;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        ready_nxt = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        if (accept) begin
            state_nxt = SHIFT;
            sout_nxt  = head(din);
            shreg_nxt = tail(din);
            valid_nxt = 1'b1;
            cnt_load  = 1'b1;
        end else if ((state == SHIFT) && !cnt_zero) begin
            sout_nxt  = head(shreg);
            shreg_nxt = tail(shreg);
            valid_nxt = 1'b1;
            cnt_dec   = 1'b1;
            done_nxt  = (cnt == CW'(1));
            ready_nxt = (cnt == CW'(1));
        end else begin
            state_nxt = IDLE;
            shreg_nxt = '0;
            ready_nxt = 1'b1;
        end
    end

    // all outputs are registered; reset aborts any frame in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            frame_done <= 1'b0;
            din_ready  <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            sout       <= sout_nxt;
            sout_valid <= valid_nxt;
            frame_done <= done_nxt;
            din_ready  <= ready_nxt;
        end
    end

endmodule

// File: doc/serializer_8.md
SERIALIZER_8 -- requirements
Module: serializer_8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits per frame (legal 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is transmitted first, 0 = bit 0 first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-006 SHALL have port din_valid, input, 1 bit: din is presented.
REQ-007 SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-008 SHALL have port sout, output, 1 bit: the serial bit, driving the downstream shift-register serial input.
REQ-009 SHALL have port sout_valid, output, 1 bit: sout carries a frame bit this cycle.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse, high during the last bit of a frame.

Function
REQ-011 SHALL accept a word on a rising edge where din_valid and din_ready are both 1 (handshake); din is ignored otherwise.
REQ-012 SHALL implement FSM states IDLE and SHIFT: IDLE->SHIFT on accept; SHIFT->IDLE after the last bit with no new accept; SHIFT->SHIFT on an accept during the last bit.
REQ-013 SHALL drive din_ready = 1 in IDLE and during the last-bit cycle of SHIFT, and 0 otherwise, so that back-to-back frames have no gap.
REQ-014 SHALL present the first bit of an accepted word on sout in the cycle after the accepting edge (latency 1), then one bit per cycle for WIDTH consecutive cycles.
REQ-015 SHALL follow bit order per MSB_FIRST, so that a downstream shift-left register holds din[WIDTH-1:0] exactly after WIDTH shifts when MSB_FIRST = 1.
REQ-016 SHALL hold sout_valid = 1 for exactly WIDTH cycles per frame and 0 in IDLE.
REQ-017 SHALL drive sout = 0 whenever sout_valid = 0.
REQ-018 SHALL assert frame_done only in the cycle carrying the final bit, coincident with sout_valid = 1.
REQ-019 SHALL keep a bit counter of $clog2(WIDTH) bits that loads WIDTH-1 on accept and decrements in SHIFT; the last bit is count = 0; the counter shall not wrap below 0.
REQ-020 SHALL drive all outputs (sout, sout_valid, frame_done, din_ready) from registers or from state alone, with no combinational path from din or din_valid to any output.
REQ-021 SHALL leave the captured word unaffected by din changes after acceptance.

Reset
REQ-022 SHALL, while reset = 1, hold the FSM in IDLE, counter = 0, shift data = 0, sout = 0, sout_valid = 0, frame_done = 0, din_ready = 0.
REQ-023 SHALL raise din_ready on the first rising clk edge after reset deasserts.
REQ-024 SHALL, on reset asserted mid-frame, abort the frame immediately (asynchronously) and never resume the partial frame.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, SHIFT) and the constant DEFAULT_WIDTH = 8 in a shared package ser_pkg.
REQ-026 SHALL contain exactly one sub-module, bitcnt: a loadable down-counter with async reset, providing a zero flag.
REQ-027 SHALL use only synthesizable constructs, with one always_ff for registered state and one always_comb for next-state logic.

Verification
REQ-028 SHALL verify a single frame: reset, then din = 8'hA5 with a 1-cycle din_valid -> sout = 1,0,1,0,0,1,0,1 starting one cycle after accept, sout_valid high for 8 cycles, frame_done on the 8th bit, and a chained serial-in shift register q = 8'hA5.
REQ-029 SHALL verify back-to-back frames: din_valid held with 8'hFF then 8'h00 -> 16 contiguous valid bits, no idle cycle between frames, two frame_done pulses 8 cycles apart.
REQ-030 SHALL verify backpressure: din_valid asserted at the 3rd bit of a frame with din = 8'h3C -> not accepted until the last-bit cycle, and the next frame is 8'h3C.
REQ-031 SHALL verify reset mid-frame: reset pulse during the 4th bit -> sout, sout_valid, and frame_done go to 0 immediately, din_ready = 1 one edge after release, and no residual bits appear.
REQ-032 SHALL verify the LSB-first configuration: MSB_FIRST = 0, WIDTH = 4, din = 4'b0001 -> sout = 1,0,0,0.
